// File: rtl/e_resp_pkg.sv
// Shared definitions for the E-clock synchronous responder: register map,
// STATUS bit layout, access state encoding and the STATUS word packer.
package e_resp_pkg;

    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_TIMER_HI = 2'd2;
    localparam logic [1:0] REG_TIMER_LO = 2'd3;

    localparam int ST_COUNT_HI = 15;
    localparam int ST_COUNT_LO = 13;
    localparam int ST_FULL     = 12;
    localparam int ST_EMPTY    = 11;
    localparam int ST_OVF      = 10;
    localparam int ST_UNF      = 9;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } acc_state_e;

    function automatic logic [15:0] status_word(
        input logic [2:0] cnt,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic       unf
    );
        logic [15:0] w;
        w = '0;
        w[ST_COUNT_HI:ST_COUNT_LO] = cnt;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        w[ST_OVF]   = ovf;
        w[ST_UNF]   = unf;
        return w;
    endfunction

endpackage

// File: rtl/e_resp_fifo.sv
// Mailbox byte FIFO. The parent arbitrates pop and never pushes into a full
// FIFO unless it pops on the same edge.
module e_resp_fifo
    import e_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/e_sync_responder.sv
// 68K VPA/VMA responder: mailbox FIFO, status and E-tick timer registers.
// Define E_TIMER_SNAPSHOT_EN to build the timer/snapshot registers.
module e_sync_responder
    import e_resp_pkg::*;
#(
    parameter logic [11:0] BASE_HI    = 12'hEC0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        e_clock,
    input  logic        rst_pistorm_mode,
    input  logic        m68k_as_n,
    input  logic        m68k_vma_n,
    input  logic        m68k_rw,
    input  logic        m68k_uds_n,
    input  logic        m68k_lds_n,
    input  logic [23:1] m68k_a,
    input  logic [15:0] m68k_d_in,
    output logic [15:0] d_out,
    output logic        d_oe,
    output logic        vpa_n,
    input  logic        pop,
    output logic        pop_ack,
    output logic [7:0]  fifo_q,
    output logic        fifo_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    acc_state_e    state_q, state_d;
    logic          rw_q, rw_d;
    logic [15:0]   rd_latch_q, rd_latch_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          pop_ack_q, pop_ack_d;

    logic          hit, sel, rd_sel, wr_sel;
    logic [1:0]    idx;
    logic          data_rd, host_pop, cons_pop, pop_any;
    logic          push_req, push_ok, stat_wr;
    logic [15:0]   rd_mux;
    logic [15:0]   timer_hi_rd, timer_lo_rd;
    logic [7:0]    head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty_w;
    logic          unused_bits;

    assign unused_bits = ^{m68k_a[11:3], m68k_d_in[7:0]};

    // Decode is purely combinational so VPA answers even while held in reset.
    assign hit   = !m68k_as_n && (m68k_a[23:12] == BASE_HI);
    assign vpa_n = !hit;
    assign sel   = hit && !m68k_vma_n && (!m68k_uds_n || !m68k_lds_n);
    assign idx   = m68k_a[2:1];

    e_resp_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (e_clock),
        .rst       (rst_pistorm_mode),
        .push      (push_ok),
        .push_data (m68k_d_in[15:8]),
        .pop       (pop_any),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty_w)
    );

`ifdef E_TIMER_SNAPSHOT_EN
    logic [31:0] timer_q, timer_d;
    logic [15:0] snap_q, snap_d;

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wr_sel && idx == REG_TIMER_HI) begin
            timer_d = '0;
        end
        snap_d = snap_q;
        // Snapshot the low half of the pre-increment value seen by the HI read.
        if (rd_sel && idx == REG_TIMER_HI) begin
            snap_d = timer_q[15:0];
        end
    end

    always_ff @(posedge e_clock or posedge rst_pistorm_mode) begin
        if (rst_pistorm_mode) begin
            timer_q <= '0;
            snap_q  <= '0;
        end else begin
            timer_q <= timer_d;
            snap_q  <= snap_d;
        end
    end

    assign timer_hi_rd = timer_q[31:16];
    assign timer_lo_rd = snap_q;
`else
    assign timer_hi_rd = 16'h0000;
    assign timer_lo_rd = 16'h0000;
`endif

    always_comb begin
        rd_sel   = sel && m68k_rw;
        wr_sel   = sel && !m68k_rw;
        data_rd  = rd_sel && (idx == REG_DATA);
        host_pop = data_rd && !fifo_empty_w;
        cons_pop = pop && !fifo_empty_w && !host_pop;
        pop_any  = host_pop || cons_pop;
        push_req = wr_sel && (idx == REG_DATA) && !m68k_uds_n;
        // A same-edge pop frees a slot, so a push into a full FIFO still lands.
        push_ok  = push_req && (!fifo_full || pop_any);
        stat_wr  = wr_sel && (idx == REG_STATUS) && !m68k_uds_n;

        case (idx)
            REG_DATA:     rd_mux = fifo_empty_w ? 16'h0000 : {head, 8'h00};
            REG_STATUS:   rd_mux = status_word(3'(fifo_count), fifo_full,
                                               fifo_empty_w, ovf_q, unf_q);
            REG_TIMER_HI: rd_mux = timer_hi_rd;
            default:      rd_mux = timer_lo_rd;
        endcase

        ovf_d = ovf_q;
        if (stat_wr && m68k_d_in[ST_OVF]) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop_any) ovf_d = 1'b1;

        unf_d = unf_q;
        if (stat_wr && m68k_d_in[ST_UNF]) unf_d = 1'b0;
        if (data_rd && fifo_empty_w) unf_d = 1'b1;

        state_d    = sel ? ST_ACCESS : ST_IDLE;
        rw_d       = sel ? m68k_rw : rw_q;
        rd_latch_d = rd_sel ? rd_mux : rd_latch_q;
        pop_ack_d  = cons_pop;
    end

    always_ff @(posedge e_clock or posedge rst_pistorm_mode) begin
        if (rst_pistorm_mode) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            rd_latch_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            pop_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            rd_latch_q <= rd_latch_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            pop_ack_q  <= pop_ack_d;
        end
    end

    // Read data is driven only during the E-high half of the access.
    assign d_oe       = (state_q == ST_ACCESS) && rw_q && e_clock && !m68k_as_n;
    assign d_out      = rd_latch_q;
    assign pop_ack    = pop_ack_q;
    assign fifo_q     = head;
    assign fifo_empty = fifo_empty_w;

endmodule

// File: doc/e_sync_responder.md
Name: e_sync_responder

Overview:
- 68K-bus target that answers 6800-style synchronous (VPA/VMA) cycles inside a fixed address window. It is the responder for the VMA/E-clock cycles that the bus initiator generates.
- Exposes four 16-bit registers to the 68K:
  - a 4x8 mailbox FIFO;
  - FIFO status;
  - a 32-bit E-tick timer, read through a hi/lo snapshot pair.
- A local consumer drains the FIFO through a pop/ack handshake.
- Sits beside the RAM logic in the CPLD top level; the top level does all tri-stating.

Parameters:
- BASE_HI, 12'hEC0, value matched against m68k_a[23:12] to select the window.
- FIFO_DEPTH, 4, mailbox depth; must be a power of two.

Ports:
- e_clock  in  1  E clock; all state updates on its rising edge.
- rst_pistorm_mode  in  1  asynchronous, active-high reset.
- m68k_as_n  in  1  address strobe.
- m68k_vma_n  in  1  valid memory address from the initiator.
- m68k_rw  in  1  1=read, 0=write.
- m68k_uds_n  in  1  upper data strobe.
- m68k_lds_n  in  1  lower data strobe.
- m68k_a  in  23  address bits 23:1.
- m68k_d_in  in  16  data bus input.
- d_out  out  16  read data.
- d_oe  out  1  top level drives d_out onto the bus when high.
- vpa_n  out  1  valid peripheral address; top level tri-states it when high.
- pop  in  1  consumer requests one FIFO byte.
- pop_ack  out  1  one-E-cycle pulse: the pop was taken.
- fifo_q  out  8  FIFO head.
- fifo_empty  out  1  FIFO empty flag.

Behaviour:
- Decode and select:
  - hit = !as_n & (a[23:12]==BASE_HI).
  - vpa_n = !hit. It is combinational and independent of reset, so the initiator always reaches a VMA cycle.
  - sel = hit & !vma_n & (!uds_n | !lds_n).
  - Register index = a[2:1]; a[11:3] is ignored (aliases).
- Access state machine, two states:
  - IDLE: on a rising edge with sel, capture index and rw, perform the access on that same edge, then go to ACCESS.
  - ACCESS: on a rising edge with sel, start a new access (back-to-back cycles are allowed). Otherwise go to IDLE.
  - Reset state: IDLE.
- Read data path:
  - rd_latch is loaded on the capture edge.
  - d_out = rd_latch.
  - d_oe = (state==ACCESS) & rw_l & e_clock & !as_n, i.e. data is driven only during the E-high phase of the access.
  - Reset: rd_latch=0, d_oe=0.
- Registers. All bytes carried on D[15:8] unless stated.
  - 0 DATA:
    - Write with !uds_n pushes D[15:8].
    - Read returns {head,8'h00} and pops.
    - Read while empty returns 0x0000, no pop, and sets unf.
  - 1 STATUS:
    - Read returns {count[2:0],full,empty,ovf,unf,9'b0}.
    - Write with !uds_n: D[10]=1 clears ovf, D[9]=1 clears unf; write-1-to-clear.
  - 2 TIMER_HI:
    - Read returns timer[31:16] and copies timer[15:0] into snap.
    - Write clears timer to 0 on that edge; the write overrides the increment.
  - 3 TIMER_LO:
    - Read returns snap.
    - Writes are ignored.
- Timer and snapshot:
  - timer increments by 1 every rising edge and wraps 0xFFFFFFFF to 0.
  - The value captured on a read is the pre-increment value.
- FIFO:
  - count is 0..4; full = count==4, empty = count==0.
  - Push while full drops the byte and sets ovf.
  - Pop sources:
    - 68K DATA read has priority.
    - Consumer pop is honoured only when not empty and no 68K pop occurs on that edge; pop_ack=1 for that one cycle.
    - A refused consumer pop leaves pop_ack=0; the consumer holds pop and retries.
  - Push and pop on the same edge: both happen and count is unchanged. This holds when full as well: no ovf is set, and the pop frees the slot first.
- Reset:
  - count=0, pointers=0, ovf=unf=0, timer=0, snap=0, pop_ack=0.
  - fifo_empty=1, fifo_q=0.
  - Reset during ACCESS returns to IDLE immediately and drops d_oe.

Optional Feature:
- Macro E_TIMER_SNAPSHOT_EN.
- Defined: the timer and snap registers exist as described.
- Undefined: no timer or snap flops; TIMER_HI and TIMER_LO read 0x0000 and writes have no effect. The FIFO and STATUS are unchanged.

Decomposition:
- Package e_resp_pkg holds:
  - register indices REG_DATA=0, REG_STATUS=1, REG_TIMER_HI=2, REG_TIMER_LO=3;
  - STATUS bit positions: COUNT 15:13, FULL 12, EMPTY 11, OVF 10, UNF 9.
- Sub-module e_resp_fifo:
  - 4x8 storage with count, full and empty;
  - push input, and a pop input already arbitrated by the parent.

Test Plan:
- Decode:
  - AS low at 0xEC0004 gives vpa_n=0.
  - AS low at 0xED0004 gives vpa_n=1.
  - VMA high: no register change.
- Push/read:
  - Write 0xA500 then 0x3C00 to DATA, then read STATUS: 0x4000 (count=2).
  - Read DATA returns 0xA500; d_oe is high only while e_clock=1.
- Overflow:
  - Five pushes 0x11..0x55 leave count=4 and ovf=1; fifo_q=0x11.
  - STATUS write 0x0400 clears ovf.
  - Empty DATA read returns 0x0000 and sets unf.
- Arbitration:
  - pop held with a same-edge 68K DATA read on 2 entries: 68K gets entry0, pop_ack=0.
  - Next edge: pop_ack=1 and fifo_q advances to empty.
- Timer:
  - Write TIMER_HI at timer 0x0001FFFE, then 0x10 edges later read HI: 0x0000, and LO: the same-edge snapshot 0x000F.
  - Without E_TIMER_SNAPSHOT_EN both reads return 0x0000.
- Reset:
  - Assert rst_pistorm_mode mid-read: d_oe=0 the same instant.
  - After release: STATUS reads 0x0800 (empty=1) and TIMER_HI reads 0x0000.
